// File: rtl/icache_fill_responder_pkg.sv
// Shared types and geometry for the icache line-fill responder.
package icache_fill_responder_pkg;
  localparam int LINE_BITS        = 256;
  localparam int BEAT_BITS        = 64;
  localparam int BEATS_PER_LINE   = LINE_BITS / BEAT_BITS;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEAT_IDX_BITS    = $clog2(BEATS_PER_LINE);
  localparam int TAG_BITS         = 32 - LINE_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/icache_fill_linebuf.sv
// Single-line buffer: beat-indexed data write port plus tag/valid updated at fill commit.
module icache_fill_linebuf #(
  parameter int LINE_BITS     = 256,
  parameter int BEAT_BITS     = 64,
  parameter int TAG_BITS      = 27,
  parameter int BEAT_IDX_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [BEAT_IDX_BITS-1:0] wr_beat_i,
  input  logic [BEAT_BITS-1:0]     wr_data_i,
  input  logic                     commit_i,
  input  logic                     commit_valid_i,
  input  logic [TAG_BITS-1:0]      commit_tag_i,
  input  logic                     clr_valid_i,
  output logic [LINE_BITS-1:0]     data_o,
  output logic [TAG_BITS-1:0]      tag_o,
  output logic                     valid_o
);
  logic [LINE_BITS-1:0] data_q;
  logic [TAG_BITS-1:0]  tag_q;
  logic                 valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        data_q[wr_beat_i*BEAT_BITS +: BEAT_BITS] <= wr_data_i;
      end
      // A commit carries its own valid value, so a flush seen during the fill wins here.
      if (commit_i) begin
        tag_q   <= commit_tag_i;
        valid_q <= commit_valid_i;
      end else if (clr_valid_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign tag_o   = tag_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/icache_fill_responder.sv
// Serves L1 icache line requests from a one-line buffer, filling it beat by beat from memory.
module icache_fill_responder #(
  parameter int LINE_BITS = icache_fill_responder_pkg::LINE_BITS,
  parameter int BEAT_BITS = icache_fill_responder_pkg::BEAT_BITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              L2_read_en,
  input  logic [31:0]                       L2_addr_read,
  output logic [LINE_BITS-1:0]              L2_block_read,
  output logic                              L2_stall,
  input  logic                              flush,
  output logic                              mem_req,
  output logic [31:0]                       mem_addr,
  input  logic                              mem_ack,
  input  logic [BEAT_BITS-1:0]              mem_rdata,
  output icache_fill_responder_pkg::state_e dbg_state_o
);
  import icache_fill_responder_pkg::*;

  localparam logic [BEAT_IDX_BITS-1:0] LAST_BEAT = BEAT_IDX_BITS'(BEATS_PER_LINE - 1);

  state_e                   state_q;
  logic                     stall_q;
  logic                     mem_req_q;
  logic [31:0]              mem_addr_q;
  logic [BEAT_IDX_BITS-1:0] beat_q;
  logic [TAG_BITS-1:0]      req_line_q;
  logic                     abandon_q;
  logic                     flush_pend_q;

  logic [LINE_BITS-1:0]     buf_data;
  logic [TAG_BITS-1:0]      buf_tag;
  logic                     buf_valid;
  logic [TAG_BITS-1:0]      addr_line;
  logic [BEAT_IDX_BITS-1:0] beat_nxt;
  logic                     hit;
  logic                     beat_wr;
  logic                     fill_done;
  logic                     buf_clr;
  logic                     unused_addr_bits;

  assign addr_line        = L2_addr_read[31:LINE_OFFSET_BITS];
  assign unused_addr_bits = ^L2_addr_read[LINE_OFFSET_BITS-1:0];
  assign beat_nxt         = beat_q + 1'b1;
  // A flush arriving with the request must not be answered from the line it invalidates.
  assign hit       = buf_valid && (buf_tag == addr_line) && !flush;
  assign beat_wr   = (state_q == FILL) && mem_ack;
  assign fill_done = beat_wr && (beat_q == LAST_BEAT);
  assign buf_clr   = ((state_q == IDLE) && (flush || (L2_read_en && !hit))) ||
                     ((state_q == RESP) && flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stall_q      <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      beat_q       <= '0;
      req_line_q   <= '0;
      abandon_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (L2_read_en) begin
            req_line_q <= addr_line;
            if (hit) begin
              state_q <= RESP;
              stall_q <= 1'b0;
            end else begin
              state_q      <= FILL;
              beat_q       <= '0;
              mem_req_q    <= 1'b1;
              mem_addr_q   <= {addr_line, {BEAT_IDX_BITS{1'b0}}, 3'b000};
              abandon_q    <= 1'b0;
              flush_pend_q <= 1'b0;
            end
          end
        end
        FILL: begin
          // Once the requester lets go, the fill still lands in the buffer but is not returned.
          if (!L2_read_en) abandon_q <= 1'b1;
          if (flush) flush_pend_q <= 1'b1;
          if (mem_ack) begin
            if (beat_q == LAST_BEAT) begin
              mem_req_q <= 1'b0;
              beat_q    <= '0;
              if (abandon_q || !L2_read_en) begin
                state_q <= IDLE;
              end else begin
                state_q <= RESP;
                stall_q <= 1'b0;
              end
            end else begin
              beat_q     <= beat_nxt;
              mem_addr_q <= {req_line_q, beat_nxt, 3'b000};
            end
          end
        end
        RESP: begin
          if (!L2_read_en) begin
            state_q <= IDLE;
            stall_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          stall_q   <= 1'b1;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  icache_fill_linebuf #(
    .LINE_BITS    (LINE_BITS),
    .BEAT_BITS    (BEAT_BITS),
    .TAG_BITS     (TAG_BITS),
    .BEAT_IDX_BITS(BEAT_IDX_BITS)
  ) u_linebuf (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (beat_wr),
    .wr_beat_i     (beat_q),
    .wr_data_i     (mem_rdata),
    .commit_i      (fill_done),
    .commit_valid_i(!(flush_pend_q || flush)),
    .commit_tag_i  (req_line_q),
    .clr_valid_i   (buf_clr),
    .data_o        (buf_data),
    .tag_o         (buf_tag),
    .valid_o       (buf_valid)
  );

  assign L2_block_read = buf_data;
  assign L2_stall      = stall_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_icache_fill_responder.sv
// Bench for icache_fill_responder: table of requests, memory responder model, scoreboard queues.
module tb_icache_fill_responder;
  import icache_fill_responder_pkg::*;

  // Handshake: L2_read_en is held until L2_stall falls; mem_req is held until mem_ack, data in the ack cycle.
  logic         clk = 1'b0;
  logic         rst;
  logic         L2_read_en;
  logic [31:0]  L2_addr_read;
  logic [255:0] L2_block_read;
  logic         L2_stall;
  logic         flush;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [63:0]  mem_rdata;
  state_e       dbg_state;

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  logic [255:0] last_line;
  logic [255:0] exp_line_q[$];
  logic [31:0]  exp_addr_q[$];

  typedef struct {
    logic [31:0] addr;
    int          wait_cyc;
    int          flush_at;
    bit          flush_resp;
    bit          hit;
    int          lat;
  } vec_t;
  vec_t vecs[12];

  icache_fill_responder dut (
    .clk          (clk),
    .rst          (rst),
    .L2_read_en   (L2_read_en),
    .L2_addr_read (L2_addr_read),
    .L2_block_read(L2_block_read),
    .L2_stall     (L2_stall),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    logic [7:0] b;
    b = (8'h11 * {6'd0, a[4:3]} + 8'h11) ^ a[20:13];
    return {8{b}};
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int b = 0; b < 4; b++) l[64*b +: 64] = beat_data({a[31:5], 2'(b), 3'b000});
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after mem_wait idle cycles and checks each beat address.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (exp_addr_q.size() == 0) begin
          check("mem_req unexpected", mem_req, 0);
        end else if (wait_cnt < mem_wait) begin
          wait_cnt++;
          check("mem_addr held", mem_addr, exp_addr_q[0]);
        end else begin
          wait_cnt = 0;
          mem_ack = 1'b1;
          mem_rdata = beat_data(mem_addr);
          ack_cnt++;
          check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_req(input logic [31:0] addr, input bit exp_hit, input int exp_lat,
                        input int flush_at, input bit flush_resp, input string tag);
    int lat;
    int acks0;
    logic [255:0] exp_line;
    exp_line_q.push_back(line_of(addr));
    if (!exp_hit) for (int b = 0; b < 4; b++) exp_addr_q.push_back({addr[31:5], 2'(b), 3'b000});
    acks0 = ack_cnt;
    @(negedge clk);
    L2_read_en = 1'b1;
    L2_addr_read = addr;
    flush = (flush_at == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      L2_addr_read = $urandom;
      flush = (lat == flush_at);
    end while (L2_stall && lat < 100);
    flush = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    exp_line = exp_line_q.pop_front();
    last_line = L2_block_read;
    check({tag, " line"}, L2_block_read, exp_line);
    check({tag, " beats"}, ack_cnt - acks0, exp_hit ? 0 : 4);
    if (flush_resp) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check({tag, " resp stall after flush"}, L2_stall, 0);
      check({tag, " resp line after flush"}, L2_block_read, exp_line);
    end
    L2_read_en = 1'b0;
    @(negedge clk);
    check({tag, " stall back"}, L2_stall, 1);
    check({tag, " state idle"}, dbg_state, IDLE);
    exp_addr_q.delete();
  endtask

  initial begin
    int acks0;
    bit saw_low;
    rst = 1'b0;
    L2_read_en = 1'b0;
    L2_addr_read = '0;
    flush = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset stall", L2_stall, 1);
    check("reset mem_req", mem_req, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset line", L2_block_read, 0);
    check("reset state", dbg_state, IDLE);
    rst = 1'b0;

    vecs[0]  = '{32'h0000_1040, 0, -1, 1'b0, 1'b0, 5};
    vecs[1]  = '{32'h0000_1050, 0, -1, 1'b0, 1'b1, 1};
    vecs[2]  = '{32'h0000_105F, 0, -1, 1'b0, 1'b1, 1};
    vecs[3]  = '{32'h0000_3000, 3, -1, 1'b0, 1'b0, 17};
    vecs[4]  = '{32'h0000_3018, 0, -1, 1'b0, 1'b1, 1};
    vecs[5]  = '{32'h0000_1040, 0, -1, 1'b0, 1'b0, 5};
    vecs[6]  = '{32'h0000_2000, 0, 3, 1'b0, 1'b0, 5};
    vecs[7]  = '{32'h0000_2000, 0, -1, 1'b0, 1'b0, 5};
    vecs[8]  = '{32'h0000_2000, 0, 0, 1'b0, 1'b0, 5};
    vecs[9]  = '{32'h0000_2000, 0, -1, 1'b1, 1'b1, 1};
    vecs[10] = '{32'h0000_2000, 0, -1, 1'b0, 1'b0, 5};
    vecs[11] = '{32'h0000_5000, 1, -1, 1'b0, 1'b0, 9};

    for (int i = 0; i < 12; i++) begin
      mem_wait = vecs[i].wait_cyc;
      do_req(vecs[i].addr, vecs[i].hit, vecs[i].lat, vecs[i].flush_at, vecs[i].flush_resp,
             $sformatf("vec%0d", i));
      if (i == 0)
        check("vec0 literal line", last_line,
              {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    end
    mem_wait = 0;

    // Requester drops L2_read_en mid-fill: fill still lands, no response.
    for (int b = 0; b < 4; b++) exp_addr_q.push_back({27'(32'h7000 >> 5), 2'(b), 3'b000});
    acks0 = ack_cnt;
    @(negedge clk);
    L2_read_en = 1'b1;
    L2_addr_read = 32'h0000_7000;
    repeat (2) @(negedge clk);
    L2_read_en = 1'b0;
    saw_low = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!L2_stall) saw_low = 1'b1;
    end
    check("abort stall stayed high", saw_low, 0);
    check("abort beats", ack_cnt - acks0, 4);
    check("abort state", dbg_state, IDLE);
    check("abort mem_req", mem_req, 0);
    exp_addr_q.delete();
    do_req(32'h0000_7008, 1'b1, 1, -1, 1'b0, "abort rehit");

    // Reset pulse during beat 1 of a fill.
    for (int b = 0; b < 4; b++) exp_addr_q.push_back({27'(32'h6000 >> 5), 2'(b), 3'b000});
    @(negedge clk);
    L2_read_en = 1'b1;
    L2_addr_read = 32'h0000_6000;
    repeat (2) @(negedge clk);
    check("rst pre mem_req", mem_req, 1);
    #1 rst = 1'b1;
    #1;
    check("rst mem_req", mem_req, 0);
    check("rst stall", L2_stall, 1);
    check("rst state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    L2_read_en = 1'b0;
    exp_addr_q.delete();
    do_req(32'h0000_6000, 1'b0, 5, -1, 1'b0, "post rst");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/icache_fill_responder.md
ICACHE_FILL_RESPONDER -- requirements
Module: icache_fill_responder

Interface
REQ-001 The block SHALL have parameter LINE_BITS, default 256, meaning the L1 line width returned per request.
REQ-002 The block SHALL have parameter BEAT_BITS, default 64, meaning the memory data bus width; beats per line = LINE_BITS/BEAT_BITS (4).
REQ-003 clk  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 L2_read_en  input  1  icache miss request, held high until the line is taken.
REQ-006 L2_addr_read  input  32  request byte address; bits [4:0] ignored.
REQ-007 L2_block_read  output  256  returned line; valid only while L2_stall is low.
REQ-008 L2_stall  output  1  1 = line not ready; 0 = L2_block_read valid for the captured request.
REQ-009 flush  input  1  one-cycle pulse; invalidates the line buffer.
REQ-010 mem_req  output  1  memory beat request, held until acked.
REQ-011 mem_addr  output  32  beat address = {line[31:5], beat[1:0], 3'b000}.
REQ-012 mem_ack  input  1  beat accepted; mem_rdata valid in the same cycle.
REQ-013 mem_rdata  input  64  beat data.

Function
REQ-014 FSM states SHALL be IDLE, FILL, RESP; all outputs SHALL be registered or decoded from registered state only.
REQ-015 IDLE: L2_stall=1, mem_req=0; on L2_read_en=1, capture L2_addr_read[31:5] into req_line.
REQ-016 IDLE on request with buf_valid=1 and buf_tag==L2_addr_read[31:5]: next state RESP (hit latency 1 cycle after request).
REQ-017 IDLE on request otherwise: next state FILL, beat counter=0.
REQ-018 FILL: mem_req=1, mem_addr per REQ-011 from req_line; L2_stall=1.
REQ-019 FILL: each cycle with mem_ack=1, write mem_rdata into buffer bits [64*beat+63 : 64*beat] and increment beat; mem_ack=0 holds state.
REQ-020 FILL: on ack of beat 3, set buf_tag=req_line, buf_valid=1, next state RESP; mem_req deasserts the next cycle.
REQ-021 RESP: L2_stall=0, L2_block_read=buffer; hold until L2_read_en=0, then next state IDLE with L2_stall=1 in that same next cycle.
REQ-022 Miss latency SHALL be 1 + (number of FILL cycles) before L2_stall falls; zero-wait memory gives L2_stall low 5 cycles after request.
REQ-023 Changes on L2_addr_read after capture SHALL be ignored until return to IDLE.
REQ-024 L2_read_en falling during FILL SHALL NOT abort the fill; fill completes, buffer is updated, state goes to IDLE, RESP skipped.
REQ-025 flush in IDLE or RESP SHALL clear buf_valid next cycle; RESP still completes with the held data.
REQ-026 flush during FILL SHALL leave buf_valid=0 after the fill completes, while RESP still returns the filled line.
REQ-027 flush coincident with a request in IDLE SHALL force the miss path.
REQ-028 Beat counter SHALL be 2 bits and wrap only via state exit, never mid-fill.

Reset
REQ-029 rst high SHALL asynchronously force: state=IDLE, L2_stall=1, mem_req=0, mem_addr=0, beat=0, buf_valid=0, buf_tag=0, L2_block_read=0.
REQ-030 rst mid-FILL SHALL drop mem_req immediately; no partial line is ever marked valid.

Structure
REQ-031 A shared package SHALL hold the state typedef (IDLE, FILL, RESP), LINE_BITS, BEAT_BITS, BEATS_PER_LINE, and LINE_OFFSET_BITS=5.
REQ-032 One sub-module icache_fill_linebuf SHALL hold the 256-bit data, tag, valid bit and beat-indexed write port; the FSM stays in the top module.

Verification
REQ-033 Cold miss, addr=0x0000_1040, mem acks every cycle with beats 0x11..,0x22..,0x33..,0x44.. -> mem_addr 0x1040,0x1048,0x1050,0x1058; L2_stall low at cycle 5 with line {0x44..,0x33..,0x22..,0x11..}.
REQ-034 Repeat request to 0x0000_1050 after REQ-033 -> no mem_req; L2_stall low 1 cycle after request with same line.
REQ-035 Miss with mem_ack stalled 3 cycles between each beat -> mem_addr held stable while unacked; L2_stall low only after fourth ack.
REQ-036 flush asserted during beat 2 of a fill to 0x2000, then re-request 0x2000 -> first request served; second request issues a full 4-beat fill.
REQ-037 rst pulse during beat 1 of a fill -> mem_req=0, L2_stall=1 immediately; subsequent request to same address misses.
REQ-038 L2_read_en dropped during FILL -> state returns to IDLE after beat 3 without L2_stall falling; next request to same line hits in 1 cycle.
